// File: rtl/arm_hazard_unit.sv
// arm_hazard_unit
//   Tracks the in-flight writers in EX, MEM and WB of the forwarding ARM pipeline.
//   From them it drives the operand forwarding selects and the load-use/CPSR stall.
//   It also runs the SWI drain-to-halt sequence.
//
// Ports
//   i_clk, i_rst_b      clock, asynchronous active-low reset
//   i_dcd_*             decode-stage instruction description (valid, read mask/regs, dest,
//                       write enables, load, condition use, SWI)
//   i_flush             EX redirected the PC; squash the decode instruction
//   o_stall             hold fetch/decode; EX receives a bubble
//   o_fwd_sel           per-slot select: 00 regfile, 01 EX, 10 MEM/load data, 11 WB
//   o_pipe_empty        EX, MEM and WB all invalid
//   o_halted            sticky halt after the SWI has drained
module arm_hazard_unit #(
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned PC_REG  = 15
) (
   input  logic                   i_clk,
   input  logic                   i_rst_b,
   input  logic                   i_dcd_valid,
   input  logic [NUM_SRC-1:0]     i_dcd_read_mask,
   input  logic [4*NUM_SRC-1:0]   i_dcd_read_reg,
   input  logic [3:0]             i_dcd_dest_reg,
   input  logic                   i_dcd_rd_we,
   input  logic                   i_dcd_is_load,
   input  logic                   i_dcd_cpsr_we,
   input  logic                   i_dcd_cond_used,
   input  logic                   i_dcd_halt,
   input  logic                   i_flush,
   output logic                   o_stall,
   output logic [2*NUM_SRC-1:0]   o_fwd_sel,
   output logic                   o_pipe_empty,
   output logic                   o_halted
);

   localparam logic [3:0] PcReg = 4'(PC_REG);

   typedef struct packed {
      logic       valid;
      logic       we;
      logic [3:0] rd;
      logic       is_load;
      logic       cpsr_we;
   } entry_t;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StDrain  = 2'd1,
      StHalted = 2'd2
   } state_e;

   entry_t r_ex, r_mem, r_wb;
   entry_t w_ex_d;
   state_e r_state, w_state_d;

   logic [2*NUM_SRC-1:0] w_fwd_sel;
   logic                 w_load_use;
   logic                 w_cpsr_haz;
   logic                 w_stall;
   logic                 w_issue;
   logic                 w_pipe_empty;

   function automatic logic stage_hit(input entry_t e, input logic [3:0] src);
      return e.valid & e.we & (e.rd == src);
   endfunction

   // Youngest matching writer wins; PC reads and unmasked slots never forward.
   always_comb begin
      w_fwd_sel  = '0;
      w_load_use = 1'b0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (i_dcd_read_mask[i] && (i_dcd_read_reg[4*i +: 4] != PcReg)) begin
            if (stage_hit(r_ex, i_dcd_read_reg[4*i +: 4])) begin
               w_fwd_sel[2*i +: 2] = 2'b01;
               // Load data only exists once the load reaches MEM.
               if (r_ex.is_load) begin
                  w_load_use = 1'b1;
               end
            end else if (stage_hit(r_mem, i_dcd_read_reg[4*i +: 4])) begin
               w_fwd_sel[2*i +: 2] = 2'b10;
            end else if (stage_hit(r_wb, i_dcd_read_reg[4*i +: 4])) begin
               w_fwd_sel[2*i +: 2] = 2'b11;
            end
         end
      end
   end

   // Flags are only readable by decode once the writer has left MEM.
   assign w_cpsr_haz = i_dcd_cond_used &
                       ((r_ex.valid & r_ex.cpsr_we) | (r_mem.valid & r_mem.cpsr_we));

   assign w_pipe_empty = ~(r_ex.valid | r_mem.valid | r_wb.valid);

   always_comb begin
      w_state_d = r_state;
      w_stall   = 1'b0;
      case (r_state)
         StRun: begin
            // A flushed instruction is dropped anyway, so it never holds decode.
            w_stall = i_dcd_valid & ~i_flush & (w_load_use | w_cpsr_haz);
            if (i_dcd_valid && !i_flush && !w_stall && i_dcd_halt) begin
               w_state_d = StDrain;
            end
         end
         StDrain: begin
            w_stall = 1'b1;
            if (w_pipe_empty) begin
               w_state_d = StHalted;
            end
         end
         StHalted: begin
            w_stall = 1'b1;
         end
         default: begin
            w_state_d = StRun;
         end
      endcase
   end

   assign w_issue = i_dcd_valid & ~w_stall & ~i_flush;

   // The SWI travels down the pipe as a valid entry that writes nothing.
   always_comb begin
      w_ex_d = '0;
      if (w_issue) begin
         w_ex_d.valid   = 1'b1;
         w_ex_d.we      = i_dcd_rd_we & ~i_dcd_halt;
         w_ex_d.rd      = i_dcd_dest_reg;
         w_ex_d.is_load = i_dcd_is_load;
         w_ex_d.cpsr_we = i_dcd_cpsr_we & ~i_dcd_halt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         r_ex    <= '0;
         r_mem   <= '0;
         r_wb    <= '0;
         r_state <= StRun;
      end else begin
         r_ex    <= w_ex_d;
         r_mem   <= r_ex;
         r_wb    <= r_mem;
         r_state <= w_state_d;
      end
   end

   assign o_stall      = w_stall;
   assign o_fwd_sel    = w_fwd_sel;
   assign o_pipe_empty = w_pipe_empty;
   assign o_halted     = (r_state == StHalted);

endmodule
